reset_sequencer: RTL and testbench

- Parametrised reset controller. Successor to the three-flop reset synchroniser.
- Synchronises and debounces an external asynchronous active-low reset request (button or PLL lock). Accepts a software reset pulse.
- Enforces a minimum reset hold time, then releases NUM_CH active-low reset outputs one at a time in a fixed, staggered order.
- Sits at the top of each clock domain and feeds the reset_n of the VGA, memory and bus subsystems in dependency order.

---
 rtl/reset_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_reset_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises and debounces an external reset request, enforces a
// hold time, then releases NUM_CH active-low resets in order. Optional watchdog: RESET_SEQ_WDOG_EN.
module reset_sequencer #(
    parameter int NUM_CH        = 4,
    parameter int SYNC_STAGES   = 3,
    parameter int FILTER_CYCLES = 16,
    parameter int HOLD_CYCLES   = 64,
    parameter int STEP_CYCLES   = 16,
    parameter int CNT_W         = 16
`ifdef RESET_SEQ_WDOG_EN
    ,
    parameter int WDOG_CYCLES   = 65535
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rst_req_n_async,
    input  logic              soft_rst,
`ifdef RESET_SEQ_WDOG_EN
    input  logic              wdog_kick,
    output logic              wdog_fired,
`endif
    output logic [NUM_CH-1:0] reset_n_out,
    output logic              all_released,
    output logic [1:0]        seq_state
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] FILT_MAX  = CNT_W'(FILTER_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       filt_q, filt_d;
    logic                   req_ok;
    logic                   abort;

    state_t                 state_q, state_d;
    logic [NUM_CH-1:0]      rst_n_q, rst_n_d;
    logic                   all_q, all_d;
    logic [CNT_W-1:0]       hold_q, hold_d;
    logic [CNT_W-1:0]       step_q, step_d;
    logic [IDX_W-1:0]       idx_q, idx_d;

`ifdef RESET_SEQ_WDOG_EN
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);

    logic [CNT_W-1:0] wdog_q, wdog_d;
    logic             fired_q, fired_d;
    logic             wdog_trip;

    // A missed kick is treated exactly like a dropped request: full resequence.
    assign wdog_trip = (state_q == ST_RUN) && (wdog_q == WDOG_LAST) && !wdog_kick;
    assign abort     = !req_ok || soft_rst || wdog_trip;

    always_comb begin
        wdog_d  = wdog_q;
        fired_d = fired_q | wdog_trip;
        if ((state_q != ST_RUN) || abort || wdog_kick) begin
            wdog_d = '0;
        end else begin
            wdog_d = wdog_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_q  <= '0;
            fired_q <= 1'b0;
        end else begin
            wdog_q  <= wdog_d;
            fired_q <= fired_d;
        end
    end

    assign wdog_fired = fired_q;
`else
    assign abort = !req_ok || soft_rst;
`endif

    // Low sample clears at once (fast assert); release needs FILTER_CYCLES highs in a row.
    assign req_ok = (filt_q == FILT_MAX);

    always_comb begin
        filt_d = filt_q;
        if (!sync_q[SYNC_STAGES-1]) begin
            filt_d = '0;
        end else if (filt_q != FILT_MAX) begin
            filt_d = filt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        rst_n_d = rst_n_q;
        all_d   = all_q;
        hold_d  = hold_q;
        step_d  = step_q;
        idx_d   = idx_q;

        if (abort) begin
            state_d = ST_ASSERT;
            rst_n_d = '0;
            all_d   = 1'b0;
            hold_d  = '0;
            step_d  = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                ST_ASSERT: begin
                    if (hold_q == HOLD_LAST) begin
                        rst_n_d[0] = 1'b1;
                        step_d     = '0;
                        idx_d      = IDX_W'(1);
                        if (NUM_CH == 1) begin
                            state_d = ST_RUN;
                            all_d   = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end else begin
                        hold_d = hold_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (step_q == STEP_LAST) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (idx_q == IDX_W'(i)) begin
                                rst_n_d[i] = 1'b1;
                            end
                        end
                        step_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_RUN;
                            all_d   = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        step_d = step_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                end
                default: begin
                    state_d = ST_ASSERT;
                    rst_n_d = '0;
                    all_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            filt_q  <= '0;
            state_q <= ST_ASSERT;
            rst_n_q <= '0;
            all_q   <= 1'b0;
            hold_q  <= '0;
            step_q  <= '0;
            idx_q   <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rst_req_n_async};
            filt_q  <= filt_d;
            state_q <= state_d;
            rst_n_q <= rst_n_d;
            all_q   <= all_d;
            hold_q  <= hold_d;
            step_q  <= step_d;
            idx_q   <= idx_d;
        end
    end

    assign reset_n_out  = rst_n_q;
    assign all_released = all_q;
    assign seq_state    = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: a release-count reference model predicts outputs
// per edge; a monitor compares. Watchdog scenario is built when RESET_SEQ_WDOG_EN is defined.
module tb_reset_sequencer;

    localparam int N    = 3;
    localparam int SYNC = 2;
    localparam int F    = 4;
    localparam int H    = 8;
    localparam int STEP = 3;
    localparam int WDOG = 10;

    logic         clk;
    logic         reset;
    logic         rst_req_n_async;
    logic         soft_rst;
    logic         kick;
    logic [N-1:0] reset_n_out;
    logic         all_released;
    logic [1:0]   seq_state;
`ifdef RESET_SEQ_WDOG_EN
    logic         wdog_fired;
`endif

    reset_sequencer #(
        .NUM_CH(N), .SYNC_STAGES(SYNC), .FILTER_CYCLES(F),
        .HOLD_CYCLES(H), .STEP_CYCLES(STEP), .CNT_W(16)
`ifdef RESET_SEQ_WDOG_EN
        , .WDOG_CYCLES(WDOG)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .rst_req_n_async(rst_req_n_async),
        .soft_rst(soft_rst),
`ifdef RESET_SEQ_WDOG_EN
        .wdog_kick(kick),
        .wdog_fired(wdog_fired),
`endif
        .reset_n_out(reset_n_out),
        .all_released(all_released),
        .seq_state(seq_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [N-1:0] rn;
        logic         ar;
        logic [1:0]   st;
        logic         wf;
    } exp_t;

    exp_t exp_q[$];
    bit   done = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Reference model: samples in flight through the synchroniser, run of consecutive
    // high samples, and count of consecutive non-aborted edges (m_run).
    bit dly[$];
    int streak, m_run, m_rel, wd;
    bit reqok, fired;

    task automatic model_edge(input bit rs, input bit a, input bit s, input bit k);
        bit seen, ab, trip, full_prev;
        int t;
        if (rs) begin
            dly = {};
            for (int i = 0; i < SYNC; i++) dly.push_back(1'b0);
            streak = 0; reqok = 0; m_run = 0; m_rel = 0; wd = 0; fired = 0;
        end else begin
            seen = dly.pop_front();
            dly.push_back(a);
            full_prev = (m_rel == N);
            trip = 1'b0;
`ifdef RESET_SEQ_WDOG_EN
            trip = full_prev && (wd == WDOG - 1) && !k;
`endif
            ab = !reqok || s || trip;
            streak = seen ? ((streak < F) ? streak + 1 : F) : 0;
            reqok = (streak >= F);
            wd = (ab || !full_prev || k) ? 0 : wd + 1;
            fired = fired | trip;
            m_run = ab ? 0 : m_run + 1;
            if (m_run < H) begin
                m_rel = 0;
            end else begin
                t = 1 + (m_run - H) / STEP;
                m_rel = (t > N) ? N : t;
            end
        end
    endtask

    task automatic cyc(input bit rs, input bit a, input bit s, input bit k);
        exp_t e;
        @(negedge clk);
        reset = rs;
        rst_req_n_async = a;
        soft_rst = s;
        kick = k;
        model_edge(rs, a, s, k);
        e.rn = N'((32'd1 << m_rel) - 1);
        e.ar = (m_rel == N);
        e.st = (m_rel == 0) ? 2'd0 : ((m_rel == N) ? 2'd2 : 2'd1);
        e.wf = fired;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        logic wf_act;
        int   edge_n;
        edge_n = 0;
        while (!done) begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                edge_n++;
                wf_act = 1'b0;
`ifdef RESET_SEQ_WDOG_EN
                wf_act = wdog_fired;
`endif
                checks++;
                if (reset_n_out !== e.rn || all_released !== e.ar ||
                    seq_state !== e.st || wf_act !== e.wf) begin
                    errors++;
                    $display("FAIL edge%0d outputs: got rn=%b ar=%b st=%0d wf=%b, expected rn=%b ar=%b st=%0d wf=%b",
                             edge_n, reset_n_out, all_released, seq_state, wf_act,
                             e.rn, e.ar, e.st, e.wf);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : stim
        int seg_len, mode;
        bit a, rs, s, k;
        reset = 1'b1; rst_req_n_async = 1'b1; soft_rst = 1'b0; kick = 1'b0;

        // Power-up with request already high.
        repeat (5) cyc(1, 1, 0, 0);
        repeat (40) cyc(0, 1, 0, 0);

        // One-cycle glitch while running.
        cyc(0, 0, 0, 0);
        repeat (40) cyc(0, 1, 0, 0);

        // Bounce shorter than the filter window.
        for (int i = 0; i < 5; i++) begin
            repeat (3) cyc(0, 1, 0, 0);
            repeat (2) cyc(0, 0, 0, 0);
        end
        repeat (40) cyc(0, 1, 0, 0);

        // Soft reset one cycle after channel 0 releases.
        cyc(1, 1, 0, 0);
        for (int i = 0; i < 100 && m_rel != 1; i++) cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 0);
        repeat (30) cyc(0, 1, 0, 0);

        // Soft reset on the very edge that would release channel 1.
        cyc(1, 1, 0, 0);
        for (int i = 0; i < 100 && m_run != H + STEP - 1; i++) cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 0);
        repeat (30) cyc(0, 1, 0, 0);

`ifdef RESET_SEQ_WDOG_EN
        cyc(1, 1, 0, 0);
        repeat (60) cyc(0, 1, 0, 0);
        for (int i = 0; i < 80; i++) cyc(0, 1, 0, (i % 5) == 4);
`endif

        seg_len = 0;
        mode = 2;
        for (int i = 0; i < 3000; i++) begin
            if (seg_len == 0) begin
                seg_len = $urandom_range(1, 60);
                mode = $urandom % 5;
            end
            seg_len--;
            a  = (mode == 0) ? 1'($urandom % 2) : ((mode == 1) ? 1'b0 : 1'b1);
            rs = ($urandom % 300) == 0;
            s  = ($urandom % 80) == 0;
            k  = ($urandom % 6) == 0;
            cyc(rs, a, s, k);
        end

        repeat (3) @(posedge clk);
        done = 1'b1;
    end

endmodule
